// File: rtl/multicycle_controlunit.sv
// multicycle_controlunit: multicycle RV control FSM with shared memory handshake, timeout trap
// and optional retired counter (CTRL_PERF_CNT_EN).
module multicycle_controlunit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCsrc,
  output logic                 RegWrite,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [1:0]           ImmSrc,
  output logic                 ResultSrc,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retired
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t        r_state, w_next;
  logic [WW-1:0] r_wait;
  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic          w_addi, w_add, w_lw, w_sw, w_beq, w_bne, w_legal, w_timeout;
  logic          w_unused;
  assign w_op      = instr[6:0];
  assign w_f3      = instr[14:12];
  assign w_addi    = w_op == 7'b0010011 && w_f3 == 3'b000;
  assign w_add     = w_op == 7'b0110011 && w_f3 == 3'b000 && instr[31:25] == 7'd0;
  assign w_lw      = w_op == 7'b0000011 && w_f3 == 3'b010;
  assign w_sw      = w_op == 7'b0100011 && w_f3 == 3'b010;
  assign w_beq     = w_op == 7'b1100011 && w_f3 == 3'b000;
  assign w_bne     = w_op == 7'b1100011 && w_f3 == 3'b001;
  assign w_legal   = w_addi | w_add | w_lw | w_sw | w_beq | w_bne;
  assign w_unused  = &{1'b0, instr[24:15], instr[11:7]};
  // Fires on the last permitted wait cycle, so the trap lands exactly MEM_TIMEOUT waits in.
  assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready && r_wait == WW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_wait <= '0;
    else     r_wait <= (MemReq && !mem_ready) ? r_wait + 1'b1 : '0;
  always_comb begin
    w_next    = r_state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = 3'b000;
    ALUsrc    = 1'b1;
    ImmSrc    = 2'b00;
    ResultSrc = 1'b0;
    trap      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        MemReq  = 1'b1;
        IRWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : (w_timeout ? S_TRAP : S_FETCH);
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        ALUsrc   = !(w_add | w_beq | w_bne);
        ALUctrl  = (w_beq | w_bne) ? 3'b001 : 3'b000;
        ImmSrc   = (w_beq | w_bne) ? 2'b01 : (w_sw ? 2'b10 : 2'b00);
        RegWrite = w_addi | w_add;
        PCWrite  = !(w_lw | w_sw);
        PCsrc    = (w_beq & EQ) | (w_bne & !EQ);
        w_next   = (w_lw | w_sw) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemWrite = w_sw;
        ImmSrc   = w_sw ? 2'b10 : 2'b00;
        PCWrite  = w_sw & mem_ready;
        w_next   = mem_ready ? (w_sw ? S_FETCH : S_WB) : (w_timeout ? S_TRAP : S_MEM);
      end
      S_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        PCWrite   = 1'b1;
        w_next    = S_FETCH;
      end
      default: trap = 1'b1;
    endcase
    if (rst) begin
      MemReq   = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      PCsrc    = 1'b0;
      RegWrite = 1'b0;
      ALUctrl  = 3'b000;
      ALUsrc   = 1'b0;
      ImmSrc   = 2'b00;
      ResultSrc = 1'b0;
      trap     = 1'b0;
    end
  end
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_retired;
  always_ff @(posedge clk or posedge rst)
    if (rst)          r_retired <= '0;
    else if (PCWrite) r_retired <= r_retired + 1'b1;
  assign retired = r_retired;
`else
  assign retired = '0;
`endif
endmodule

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Multicycle control FSM for the reduced RISC-V core, replacing the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a ready handshake. It drives the same datapath strobes as before, plus PC/IR write enables, a memory-timeout trap and an optional retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max cycles MemReq may wait for mem_ready before trapping; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  IR contents from datapath, valid from DECODE onward.
- EQ  in  1  ALU equality flag, valid in EXEC.
- mem_ready  in  1  memory completes the access presented this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  store strobe, only with MemReq.
- IRWrite  out  1  latch fetched word into IR.
- PCWrite  out  1  update PC.
- PCsrc  out  1  0 = PC+4, 1 = PC+imm.
- RegWrite  out  1  register file write.
- ALUctrl  out  3  000 add, 001 sub.
- ALUsrc  out  1  1 = immediate operand, 0 = rs2.
- ImmSrc  out  2  00 I-type, 01 B-type, 10 S-type.
- ResultSrc  out  1  0 = ALU result, 1 = memory data.
- trap  out  1  sticky fault flag.
- retired  out  CNT_WIDTH  retired-instruction count.

## Operation
- Supported: addi (0010011/000), add (0110011/000, funct7=0), lw (0000011/010), sw (0100011/010), beq (1100011/000), bne (1100011/001). Anything else is illegal.
- Default for all outputs in every state: 0, except ALUsrc = 1.
- FETCH: MemReq=1. On mem_ready: IRWrite=1, go to DECODE. Otherwise stay.
- DECODE: no strobes. Illegal instr goes to TRAP; otherwise go to EXEC.
- EXEC:
  - addi: RegWrite=1, PCWrite=1, go to FETCH.
  - add: ALUsrc=0, RegWrite=1, PCWrite=1, go to FETCH.
  - beq/bne: ALUsrc=0, ALUctrl=001, ImmSrc=01, PCWrite=1. PCsrc=EQ for beq, PCsrc=!EQ for bne. Go to FETCH.
  - lw/sw: address add (ImmSrc=00 for lw, 10 for sw), go to MEM.
- MEM: MemReq=1, ALUsrc=1, ImmSrc held from EXEC, MemWrite=1 for sw. On mem_ready:
  - sw: PCWrite=1, go to FETCH.
  - lw: go to WB.
- WB: RegWrite=1, ResultSrc=1, PCWrite=1, go to FETCH.
- TRAP: all strobes 0, trap=1. Stays in TRAP until rst.
- Wait counter (width clog2(MEM_TIMEOUT+1)):
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle MemReq=1 && !mem_ready.
  - Reaching MEM_TIMEOUT without ready goes to TRAP next cycle; no IRWrite or PCWrite is issued.
- Retired count (when enabled) increments by 1 on every cycle PCWrite=1 and wraps modulo 2^CNT_WIDTH.

## Timing
- Outputs are Moore/Mealy decode of registered state; mem_ready and EQ act combinationally within the cycle.
- mem_ready is sampled in the same cycle MemReq is high. Zero-wait memory means ready in that same cycle.
- Cycle counts with zero-wait memory:
  - addi/add/branch: 3 (FETCH, DECODE, EXEC).
  - sw: 4.
  - lw: 5.
  - Each wait cycle adds 1.
- While rst is high, all outputs are 0, trap=0 and retired=0; state=FETCH and the wait counter is 0. The first cycle after release is FETCH.
- rst asserted mid-instruction aborts it immediately; no partial PCWrite or RegWrite occurs after the assertion edge.
- mem_ready high outside FETCH/MEM is ignored.

## Configuration
- CTRL_PERF_CNT_EN defined: retired counter implemented as specified.
- Not defined: retired tied to 0, no counter flops. All other behaviour is identical.

## Test plan
- Reset, zero-wait memory, addi x1,x0,5 (0x00500093) -> IRWrite in cycle 0, RegWrite=PCWrite=1 in cycle 2, PCsrc=0, retired=1.
- bne (0x00209463) with EQ=0 -> EXEC has PCsrc=1, ALUctrl=001, ImmSrc=01. Repeat with EQ=1 -> PCsrc=0. Both give PCWrite=1.
- lw with mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles, then WB with RegWrite=1, ResultSrc=1. Total 8 cycles, MemWrite never 1.
- sw, MEM_TIMEOUT=15, mem_ready held low -> after 15 wait cycles trap=1 sticky, PCWrite never pulses; rst clears trap.
- Opcode 0x0000007F -> DECODE to TRAP, no RegWrite or MemReq after fetch.
- rst pulsed during lw MEM wait -> outputs 0 immediately, FETCH after release, retired=0.
